// File: rtl/cu_seq_v2_if.sv
// Handshake and control bundle between the cu_seq_v2 sequencer and its environment.
// master drives the run request, IR fields, ALU ack and flags; slave is the sequencer.
interface cu_seq_v2_if #(
  parameter int OP_W = 6
);
  logic            start;
  logic [OP_W-1:0] op;
  logic            ra;
  logic            ack_alu;
  logic [2:0]      flags;
  logic            finish;
  logic            busy;
  logic            alu_start;
  logic            err;
  logic [15:0]     c;

  modport master (
    output start, op, ra, ack_alu, flags,
    input  finish, busy, alu_start, err, c
  );

  modport slave (
    input  start, op, ra, ack_alu, flags,
    output finish, busy, alu_start, err, c
  );
endinterface

// File: rtl/cu_seq_v2.sv
// Control sequencer for the 16-bit ACC/X/Y processor: fetch, decode, ALU handshake, trap.
// Define CU_ALU_TIMEOUT_EN to add the AWAIT timeout counter and its trap arc.
module cu_seq_v2 #(
  parameter int OP_W   = 6,
  parameter int ALU_TO = 64,
  parameter int TO_W   = 8
) (
  input logic        clk,
  input logic        rst,
  cu_seq_v2_if.slave bus
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT, S_F0, S_F1, S_DEC, S_IMM, S_LDX, S_LDY, S_STX, S_STY,
    S_AGEN, S_AWAIT, S_AWB, S_MRD, S_MWR, S_AOP, S_AACC, S_BR, S_TRAP
  } state_t;

  localparam logic [1:0] RET_LD  = 2'd1;
  localparam logic [1:0] RET_ST  = 2'd2;
  localparam logic [1:0] RET_ACC = 2'd3;

  localparam bit CFG_OK = (ALU_TO >= 1) && (ALU_TO < (1 << TO_W));

  if (!CFG_OK) begin : g_cfg_bad
    $error("cu_seq_v2: ALU_TO must lie in [1, 2**TO_W - 1]");
  end

  state_t      state_q, state_d;
  logic [1:0]  ret_q, ret_d;
  logic [15:0] c_q, c_d;
  logic        alu_start_q, alu_start_d;
  logic        err_q, err_d;
  logic        finish_q, finish_d;
  logic        busy_q, busy_d;
  logic [5:0]  op_lo;
  logic        op_illegal;
  logic        taken;

`ifdef CU_ALU_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign op_lo      = bus.op[5:0];
  assign op_illegal = (bus.op >> 6) != '0;

  always_comb begin
    case (op_lo)
      6'd16:   taken = 1'b1;
      6'd17:   taken = bus.flags[0];
      6'd18:   taken = bus.flags[1];
      6'd19:   taken = bus.flags[2];
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic; outputs are then decoded from the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
`ifdef CU_ALU_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_INIT;
      S_INIT:  state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_DEC;
      S_DEC: begin
        if (op_illegal) begin
          state_d = S_TRAP;
        end else begin
          case (op_lo) inside
            6'd0:                     state_d = S_IDLE;
            6'd1, 6'd3, 6'd5, 6'd6:   state_d = S_IMM;
            6'd2, 6'd4:               state_d = S_AGEN;
            [6'd8:6'd15]:             state_d = S_AOP;
            [6'd16:6'd19]:            state_d = S_BR;
            default:                  state_d = S_TRAP;
          endcase
        end
      end
      S_IMM: begin
        case (op_lo)
          6'd1:    state_d = bus.ra ? S_LDY : S_LDX;
          6'd3:    state_d = bus.ra ? S_STY : S_STX;
          6'd5:    state_d = S_MRD;
          default: state_d = S_MWR;
        endcase
      end
      S_AGEN: begin
        ret_d   = (op_lo == 6'd2) ? RET_LD : RET_ST;
        state_d = S_AWAIT;
`ifdef CU_ALU_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      S_AOP: begin
        ret_d   = RET_ACC;
        state_d = S_AWAIT;
`ifdef CU_ALU_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      S_AWAIT: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus.ack_alu) begin
          state_d = (ret_q == RET_ACC) ? S_AACC : S_AWB;
        end
`ifdef CU_ALU_TIMEOUT_EN
        else if (to_q == TO_W'(ALU_TO - 1)) begin
          state_d = S_TRAP;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_AWB:   state_d = (ret_q == RET_LD) ? S_MRD : S_MWR;
      S_LDX, S_LDY, S_STX, S_STY, S_MRD, S_MWR, S_AACC, S_BR: state_d = S_F0;
      S_TRAP:  if (bus.start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase

    c_d = '0;
    case (state_d)
      S_INIT:  c_d[0]  = 1'b1;
      S_F0:    c_d[1]  = 1'b1;
      S_F1:    c_d[2]  = 1'b1;
      S_IMM:   c_d[3]  = 1'b1;
      S_LDX:   c_d[4]  = 1'b1;
      S_LDY:   c_d[5]  = 1'b1;
      S_AGEN:  if (bus.ra) c_d[7] = 1'b1; else c_d[6] = 1'b1;
      S_AOP:   c_d[8]  = 1'b1;
      S_AWB:   c_d[9]  = 1'b1;
      S_MRD:   c_d[10] = 1'b1;
      S_AACC:  c_d[11] = 1'b1;
      S_STX:   c_d[12] = 1'b1;
      S_STY:   c_d[13] = 1'b1;
      S_MWR:   c_d[14] = 1'b1;
      S_BR:    c_d[15] = taken;
      default: c_d = '0;
    endcase

    alu_start_d = (state_d == S_AGEN) || (state_d == S_AOP);
    finish_d    = (state_d == S_IDLE) || (state_d == S_TRAP);
    busy_d      = !finish_d;
    err_d       = (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= '0;
      c_q         <= '0;
      alu_start_q <= 1'b0;
      err_q       <= 1'b0;
      finish_q    <= 1'b1;
      busy_q      <= 1'b0;
`ifdef CU_ALU_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      c_q         <= c_d;
      alu_start_q <= alu_start_d;
      err_q       <= err_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
`ifdef CU_ALU_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign bus.c         = c_q;
  assign bus.alu_start = alu_start_q;
  assign bus.err       = err_q;
  assign bus.finish    = finish_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cu_seq_v2.sv
// Directed bench for cu_seq_v2 with ALU_TO=4; expected output words are written out by hand.
// Expected word layout is {finish, busy, alu_start, err, c[15:0]}.
module tb_cu_seq_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  cu_seq_v2_if #(.OP_W(6)) bus ();

  cu_seq_v2 #(.OP_W(6), .ALU_TO(4), .TO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [19:0] EXP_IDLE = {4'b1000, 16'h0000};
  localparam logic [19:0] EXP_TRAP = {4'b1001, 16'h0000};

  function automatic logic [15:0] cbit(input int n);
    logic [15:0] one;
    one = 16'd1;
    return one << n;
  endfunction

  function automatic logic [19:0] observed();
    return {bus.finish, bus.busy, bus.alu_start, bus.err, bus.c};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectBusy(input string tag, input logic a, input logic [15:0] cv);
    checkOutput(tag, observed(), {1'b0, 1'b1, a, 1'b0, cv});
  endtask

  // Drive one set of inputs, let one rising edge consume them, then sample 1 ns later.
  task automatic applyStimulus(input logic st, input logic [5:0] o, input logic r,
                               input logic ack, input logic [2:0] fl);
    bus.start   = st;
    bus.op      = o;
    bus.ra      = r;
    bus.ack_alu = ack;
    bus.flags   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic doFetch(input logic [5:0] o, input logic r, input logic [2:0] fl);
    applyStimulus(1'b1, o, r, 1'b0, fl); expectBusy("init", 1'b0, cbit(0));
    applyStimulus(1'b0, o, r, 1'b0, fl); expectBusy("f0",   1'b0, cbit(1));
    applyStimulus(1'b0, o, r, 1'b0, fl); expectBusy("f1",   1'b0, cbit(2));
    applyStimulus(1'b0, o, r, 1'b0, fl); expectBusy("dec",  1'b0, 16'h0);
  endtask

  // Called once F0 has been observed: fetch a HLT and land in IDLE.
  task automatic backToIdle();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000); expectBusy("ret_f1",  1'b0, cbit(2));
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000); expectBusy("ret_dec", 1'b0, 16'h0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000); checkOutput("ret_idle", observed(), EXP_IDLE);
  endtask

  task automatic recoverFromTrap();
    applyStimulus(1'b1, 6'd0, 1'b0, 1'b0, 3'b000); expectBusy("trap_init", 1'b0, cbit(0));
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000); expectBusy("trap_f0",   1'b0, cbit(1));
    backToIdle();
  endtask

  task automatic branchCase(input logic [5:0] o, input logic [2:0] fl, input logic tk);
    doFetch(o, 1'b0, fl);
    applyStimulus(1'b0, o, 1'b0, 1'b0, fl); expectBusy("br", 1'b0, tk ? cbit(15) : 16'h0);
    applyStimulus(1'b0, o, 1'b0, 1'b0, fl); expectBusy("br_f0", 1'b0, cbit(1));
    backToIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.ra = 1'b0; bus.ack_alu = 1'b0; bus.flags = 3'b000;
    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000);
    checkOutput("reset", observed(), EXP_IDLE);
    rst = 1'b0;
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000);
    checkOutput("idle_hold", observed(), EXP_IDLE);

    // HLT straight through fetch
    doFetch(6'd0, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 3'b000); checkOutput("hlt_idle", observed(), EXP_IDLE);

    // LDR Y
    doFetch(6'd1, 1'b1, 3'b000);
    applyStimulus(1'b0, 6'd1, 1'b1, 1'b0, 3'b000); expectBusy("ldr_imm", 1'b0, cbit(3));
    applyStimulus(1'b0, 6'd1, 1'b1, 1'b0, 3'b000); expectBusy("ldr_ldy", 1'b0, cbit(5));
    applyStimulus(1'b0, 6'd1, 1'b1, 1'b0, 3'b000); expectBusy("ldr_f0",  1'b0, cbit(1));
    backToIdle();

    // LDR X with start held high mid-instruction (must be ignored)
    doFetch(6'd1, 1'b0, 3'b000);
    applyStimulus(1'b1, 6'd1, 1'b0, 1'b0, 3'b000); expectBusy("ldrx_imm", 1'b0, cbit(3));
    applyStimulus(1'b1, 6'd1, 1'b0, 1'b0, 3'b000); expectBusy("ldrx_ldx", 1'b0, cbit(4));
    applyStimulus(1'b1, 6'd1, 1'b0, 1'b0, 3'b000); expectBusy("ldrx_f0",  1'b0, cbit(1));
    backToIdle();

    // STR X
    doFetch(6'd3, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 3'b000); expectBusy("str_imm", 1'b0, cbit(3));
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 3'b000); expectBusy("str_stx", 1'b0, cbit(12));
    applyStimulus(1'b0, 6'd3, 1'b0, 1'b0, 3'b000); expectBusy("str_f0",  1'b0, cbit(1));
    backToIdle();

    // LDA off, X base, ack on third AWAIT cycle
    doFetch(6'd2, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd2, 1'b0, 1'b0, 3'b000); expectBusy("lda_agen", 1'b1, cbit(6));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'd2, 1'b0, 1'b0, 3'b000); expectBusy("lda_await", 1'b0, 16'h0);
    end
    applyStimulus(1'b0, 6'd2, 1'b0, 1'b1, 3'b000); expectBusy("lda_awb", 1'b0, cbit(9));
    applyStimulus(1'b0, 6'd2, 1'b0, 1'b0, 3'b000); expectBusy("lda_mrd", 1'b0, cbit(10));
    applyStimulus(1'b0, 6'd2, 1'b0, 1'b0, 3'b000); expectBusy("lda_f0",  1'b0, cbit(1));
    backToIdle();

    // STA off, Y base, ack on first AWAIT cycle
    doFetch(6'd4, 1'b1, 3'b000);
    applyStimulus(1'b0, 6'd4, 1'b1, 1'b0, 3'b000); expectBusy("sta_agen",  1'b1, cbit(7));
    applyStimulus(1'b0, 6'd4, 1'b1, 1'b0, 3'b000); expectBusy("sta_await", 1'b0, 16'h0);
    applyStimulus(1'b0, 6'd4, 1'b1, 1'b1, 3'b000); expectBusy("sta_awb",   1'b0, cbit(9));
    applyStimulus(1'b0, 6'd4, 1'b1, 1'b0, 3'b000); expectBusy("sta_mwr",   1'b0, cbit(14));
    applyStimulus(1'b0, 6'd4, 1'b1, 1'b0, 3'b000); expectBusy("sta_f0",    1'b0, cbit(1));
    backToIdle();

    // LDA# and STA#
    doFetch(6'd5, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd5, 1'b0, 1'b0, 3'b000); expectBusy("ldai_imm", 1'b0, cbit(3));
    applyStimulus(1'b0, 6'd5, 1'b0, 1'b0, 3'b000); expectBusy("ldai_mrd", 1'b0, cbit(10));
    applyStimulus(1'b0, 6'd5, 1'b0, 1'b0, 3'b000); expectBusy("ldai_f0",  1'b0, cbit(1));
    backToIdle();
    doFetch(6'd6, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd6, 1'b0, 1'b0, 3'b000); expectBusy("stai_imm", 1'b0, cbit(3));
    applyStimulus(1'b0, 6'd6, 1'b0, 1'b0, 3'b000); expectBusy("stai_mwr", 1'b0, cbit(14));
    applyStimulus(1'b0, 6'd6, 1'b0, 1'b0, 3'b000); expectBusy("stai_f0",  1'b0, cbit(1));
    backToIdle();

    // ALU op with ack on first AWAIT cycle
    doFetch(6'd8, 1'b1, 3'b000);
    applyStimulus(1'b0, 6'd8, 1'b1, 1'b0, 3'b000); expectBusy("alu_aop",   1'b1, cbit(8));
    applyStimulus(1'b0, 6'd8, 1'b1, 1'b0, 3'b000); expectBusy("alu_await", 1'b0, 16'h0);
    applyStimulus(1'b0, 6'd8, 1'b1, 1'b1, 3'b000); expectBusy("alu_aacc",  1'b0, cbit(11));
    applyStimulus(1'b0, 6'd8, 1'b1, 1'b0, 3'b000); expectBusy("alu_f0",    1'b0, cbit(1));
    backToIdle();

    // ALU op with no ack
    doFetch(6'd9, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("to_aop", 1'b1, cbit(8));
`ifdef CU_ALU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("to_await", 1'b0, 16'h0);
    end
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); checkOutput("to_trap", observed(), EXP_TRAP);
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b1, 3'b000); checkOutput("trap_ack_ignored", observed(), EXP_TRAP);
    recoverFromTrap();

    // Ack in the last allowed cycle beats the timeout
    doFetch(6'd9, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("win_aop", 1'b1, cbit(8));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("win_await", 1'b0, 16'h0);
    end
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b1, 3'b000); expectBusy("win_aacc", 1'b0, cbit(11));
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("win_f0",   1'b0, cbit(1));
    backToIdle();
`else
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); expectBusy("wait_forever", 1'b0, 16'h0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 6'd9, 1'b0, 1'b0, 3'b000); checkOutput("wait_rst", observed(), EXP_IDLE);
    rst = 1'b0;
`endif

    // Branches
    branchCase(6'd17, 3'b001, 1'b1);
    branchCase(6'd17, 3'b000, 1'b0);
    branchCase(6'd16, 3'b000, 1'b1);
    branchCase(6'd18, 3'b010, 1'b1);
    branchCase(6'd19, 3'b011, 1'b0);
    branchCase(6'd19, 3'b100, 1'b1);

    // Illegal opcodes
    doFetch(6'h3F, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'h3F, 1'b0, 1'b0, 3'b000); checkOutput("ill_3f", observed(), EXP_TRAP);
    applyStimulus(1'b0, 6'h3F, 1'b0, 1'b0, 3'b000); checkOutput("ill_hold", observed(), EXP_TRAP);
    recoverFromTrap();
    doFetch(6'd7, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd7, 1'b0, 1'b0, 3'b000); checkOutput("ill_07", observed(), EXP_TRAP);
    recoverFromTrap();

    // Reset while waiting on the ALU
    doFetch(6'd10, 1'b0, 3'b000);
    applyStimulus(1'b0, 6'd10, 1'b0, 1'b0, 3'b000); expectBusy("rst_aop",   1'b1, cbit(8));
    applyStimulus(1'b0, 6'd10, 1'b0, 1'b0, 3'b000); expectBusy("rst_await", 1'b0, 16'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 6'd10, 1'b0, 1'b0, 3'b000); checkOutput("rst_in_await", observed(), EXP_IDLE);
    rst = 1'b0;
    applyStimulus(1'b0, 6'd10, 1'b0, 1'b1, 3'b000); checkOutput("rst_after", observed(), EXP_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cu_seq_v2.md
Name: cu_seq_v2

Overview:
- Second-generation control sequencer for the 16-bit accumulator/X/Y processor.
- Fetches, decodes and sequences LDR/LDA/STR/STA (register, offset and immediate forms), plus ALU register ops and conditional branches.
- Drives the datapath through a 16-bit control vector and runs an explicit start/ack handshake with the ALU.
- Adds illegal-opcode trapping and an ALU-response timeout.

Parameters:
- OP_W, 6, opcode width. Any opcode bit above bit 5 that is nonzero makes the opcode illegal.
- ALU_TO, 64, maximum cycles spent waiting for ack_alu. Must be greater than or equal to 1 and less than 2**TO_W.
- TO_W, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock; one clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  run request. Sampled only in IDLE and TRAP.
- op  in  OP_W  opcode field of IR.
- ra  in  1  register select from IR: 0 selects X, 1 selects Y.
- ack_alu  in  1  ALU done. Sampled only in AWAIT.
- flags  in  3  {C,N,Z} from the flag register. Z is bit 0.
- finish  out  1  high in IDLE and TRAP.
- busy  out  1  high in every state except IDLE and TRAP.
- alu_start  out  1  one-cycle pulse in AGEN and AOP.
- err  out  1  sticky error, high while in TRAP.
- c  out  16  datapath controls. All outputs are Moore (decoded from the state register only).

Behaviour:
- Control bit map:
  - c0 INIT: PC=0, clear registers
  - c1 AR<-PC
  - c2 IR<-M[AR], PC++
  - c3 AR<-IR.imm
  - c4 X<-M
  - c5 Y<-M
  - c6 ALU A<-X, B<-offset
  - c7 ALU A<-Y, B<-offset
  - c8 ALU A<-ACC, B<-X/Y (datapath selects by ra)
  - c9 AR<-ALU
  - c10 ACC<-M
  - c11 ACC<-ALU and latch flags
  - c12 M<-X
  - c13 M<-Y
  - c14 M<-ACC
  - c15 PC<-IR.imm
- Reset: state=IDLE, c=0, alu_start=0, err=0, finish=1, busy=0, timeout counter=0, return selector=0. Asserting rst in any state returns to IDLE on the next edge.
- IDLE: start=1 goes to INIT; otherwise stay.
- Fetch: INIT(c0) -> F0(c1) -> F1(c2) -> DEC. DEC asserts no c bit.
  - Latency from start to DEC is 4 cycles.
  - Fetch re-enters at F0 after each instruction.
- Decode from DEC:
  - 0 HLT: go to IDLE.
  - 1 LDR: IMM(c3) -> LDX(c4) if ra=0, LDY(c5) if ra=1 -> F0.
  - 3 STR: IMM(c3) -> STX(c12) if ra=0, STY(c13) if ra=1 -> F0.
  - 2 LDA off / 4 STA off: AGEN (c6 if ra=0, c7 if ra=1, alu_start) -> AWAIT -> AWB(c9) -> MRD(c10) for LDA, MWR(c14) for STA -> F0.
  - 5 LDA#: IMM(c3) -> MRD(c10) -> F0.
  - 6 STA#: IMM(c3) -> MWR(c14) -> F0.
  - 8..15 ALU ops: AOP(c8, alu_start) -> AWAIT -> AACC(c11) -> F0.
  - 16 BRA, 17 BRZ, 18 BRN, 19 BRC: BR asserts c15 if taken, then -> F0.
    - BRA: always taken.
    - BRZ: taken if flags[0].
    - BRN: taken if flags[1].
    - BRC: taken if flags[2].
    - Not taken: BR asserts no c bit.
  - Any other opcode: go to TRAP.
- Return selector: a 2-bit register written in AGEN/AOP records which exit AWAIT takes (load, store or accumulate).
- AWAIT:
  - c=0, alu_start=0. The timeout counter clears on entry and increments each cycle.
  - ack_alu=1 exits to the recorded state.
  - After ALU_TO cycles without ack, go to TRAP.
  - If ack_alu arrives in the ALU_TO-th cycle, ack wins.
  - An ack_alu asserted outside AWAIT is ignored.
- TRAP: err=1, finish=1, c=0. start=1 goes to INIT and clears err. rst also clears err.
- start is ignored while busy=1.

Optional Feature:
- Macro: CU_ALU_TIMEOUT_EN.
- Defined: the timeout counter and the AWAIT->TRAP timeout arc exist as described above.
- Undefined: no counter is instantiated. AWAIT waits indefinitely for ack_alu. err is set only by illegal opcodes.

Test Plan:
- rst, then start pulse with op=0 -> c0, c1, c2 one-hot in cycles 1-3; DEC in cycle 4; IDLE with finish=1 in cycle 5; busy=1 in cycles 1-4 only.
- op=1, ra=1 -> after DEC: c3, then c5, then c1 (F0); c4 never asserted.
- op=2, ra=0, ack_alu raised on the 3rd AWAIT cycle -> c6 with alu_start for 1 cycle, 3 cycles of c=0, then c9, c10, c1.
- op=9, ALU_TO=4, no ack -> 4 AWAIT cycles, then TRAP with err=1 and finish=1. A later start gives err=0 and c0 next cycle. With CU_ALU_TIMEOUT_EN undefined, the block stays in AWAIT 100 cycles.
- op=17 with flags=3'b001 -> BR asserts c15. op=17 with flags=3'b000 -> BR asserts c=0, next state is F0.
- op=6'h3F -> TRAP with err=1. Separately, rst asserted during AWAIT -> IDLE with all outputs at reset values on the next edge.
